// File: rtl/spi_flash_wb_reader_if.sv
// Wishbone slave-side bundle for the SPI flash reader.
// The master drives cycle/strobe/write/select/address; the slave returns the
// read word with a one-cycle acknowledge or a one-cycle error.
//   wb_cyc_i  bus cycle valid           wb_dat_o  read data, held until next ack
//   wb_stb_i  strobe                    wb_ack_o  read acknowledge
//   wb_we_i   write enable              wb_err_o  error acknowledge (writes)
//   wb_sel_i  byte select
//   wb_adr_i  byte address (ADDR_W bits)
interface spi_flash_wb_reader_if #(
    parameter int ADDR_W = 24
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/spi_flash_wb_reader.sv
// Read-only Wishbone window onto an external SPI NOR flash.
// Every read runs one SPI READ (0x03) or FAST_READ (0x0B + dummy byte)
// transaction in mode 0 and returns four flash bytes as one 32-bit word.
// Writes get a one-cycle error response and never touch the SPI pins.
// Ports:
//   wb_clk_i, wb_rst_i  clock and asynchronous active-high reset
//   wb                  Wishbone slave bundle (spi_flash_wb_reader_if.slave)
//   flash_continue      start gate: new transactions begin only while high
//   spi_sck_o           SPI clock, idle low
//   cs_n                flash chip select, active low
//   sdi / sdo           flash -> FPGA / FPGA -> flash serial data
//   wp_n, hld_n         write-protect and hold, tied inactive (high)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cs_n high, waiting for a read request (writes answered here)
// SETUP   | cs_n low, SCK low for CLK_DIV cycles before the first edge
// SHIFT   | command/address/dummy out, 32 data bits in, one bit per SCK
// DONE    | cs_n released, word assembled and acknowledged
// RECOVER | cs_n held high for CS_HOLD cycles before the next request
module spi_flash_wb_reader #(
    parameter int ADDR_W     = 24,
    parameter int CLK_DIV    = 2,
    parameter int FAST_READ  = 0,
    parameter int CS_HOLD    = 2,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    spi_flash_wb_reader_if.slave        wb,
    input  logic                        flash_continue,
    output logic                        spi_sck_o,
    output logic                        cs_n,
    input  logic                        sdi,
    output logic                        sdo,
    output logic                        wp_n,
    output logic                        hld_n
);

    localparam int NTX   = 8 + ADDR_W + 8 * FAST_READ;
    localparam int NBITS = NTX + 32;
    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REC_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [7:0] CMD = (FAST_READ != 0) ? 8'h0B : 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [NTX-1:0]     tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               sdo_q, sdo_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        dat_q, dat_d;

    logic               req;
    logic               div_tc;
    logic [31:0]        word;
    logic               unused_bits;

    // Byte select and the two low address bits do not affect a word fetch.
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0]};

    assign req    = wb.wb_cyc_i & wb.wb_stb_i;
    assign div_tc = (div_q == DIV_W'(CLK_DIV - 1));

    // The first flash byte lands in rx_q[31:24] because bits shift in MSB-first.
    assign word = (BIG_ENDIAN != 0) ? rx_q
                                    : {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        rec_d   = rec_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        sdo_d   = sdo_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req && wb.wb_we_i) begin
                    // A master holding a write sees a pulse, never a stuck error.
                    err_d = ~err_q;
                end else if (req && flash_continue && !ack_q) begin
                    // Header is left-aligned; the dummy byte (if any) is the zero fill.
                    tx_d    = NTX'({CMD, wb.wb_adr_i[ADDR_W-1:2], 2'b00}) << (8 * FAST_READ);
                    sdo_d   = CMD[7];
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = BIT_W'(NBITS - 1);
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (!req) begin
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    sdo_d   = 1'b0;
                    rec_d   = REC_W'(CS_HOLD - 1);
                    state_d = ST_RECOVER;
                end else if (div_tc) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (!req) begin
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    sdo_d   = 1'b0;
                    rec_d   = REC_W'(CS_HOLD - 1);
                    state_d = ST_RECOVER;
                end else if (div_tc) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[30:0], sdi};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            cs_n_d  = 1'b1;
                            sdo_d   = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            bit_d = bit_q - 1'b1;
                            sdo_d = tx_q[NTX-2];
                            tx_d  = tx_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DONE: begin
                // A master that gave up during the last bit gets no ack.
                if (req) begin
                    ack_d = 1'b1;
                    dat_d = word;
                end
                rec_d   = REC_W'(CS_HOLD - 1);
                state_d = ST_RECOVER;
            end

            ST_RECOVER: begin
                if (rec_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rec_d = rec_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            rec_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sdo_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            rec_q   <= rec_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            sdo_q   <= sdo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign spi_sck_o   = sck_q;
    assign cs_n        = cs_n_q;
    assign sdo         = sdo_q;
    assign wp_n        = 1'b1;
    assign hld_n       = 1'b1;
    assign wb.wb_dat_o = dat_q;
    // Responses are masked by cyc so a master that drops the cycle never sees one.
    assign wb.wb_ack_o = ack_q & wb.wb_cyc_i;
    assign wb.wb_err_o = err_q & wb.wb_cyc_i;

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
module tb_spi_flash_wb_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cyc [3];
    logic        stb [3];
    logic        we  [3];
    logic        fc  [3];
    logic [23:0] adr [3];
    logic        ack [3];
    logic        err [3];
    logic [31:0] dat [3];
    logic        csn_w  [3];
    logic        sck_w  [3];
    logic        sdo_w  [3];
    logic        wpn_w  [3];
    logic        hldn_w [3];
    logic [7:0]  cap_cmd [3];
    logic [23:0] cap_adr [3];
    int          idle_edges [3];

    int checks   = 0;
    int failures = 0;
    int pre, pre2, n_ack;

    typedef struct {
        int          inst;
        logic [31:0] dat;
    } sb_t;
    sb_t sb[$];

    // Instance 0: defaults. 1: little-endian lanes. 2: FAST_READ with CLK_DIV=1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NH = (g == 2) ? 40 : 32;
        spi_flash_wb_reader_if #(.ADDR_W(24)) bus ();
        logic sck, csn, so;
        logic si = 1'b0;
        logic sck_prev = 1'b0;
        logic csn_prev = 1'b1;
        logic [NH-1:0] hdr = '0;
        int rise_n = 0;
        int fall_n = 0;
        int idle_n = 0;

        assign bus.wb_cyc_i = cyc[g];
        assign bus.wb_stb_i = stb[g];
        assign bus.wb_we_i  = we[g];
        assign bus.wb_sel_i = 4'hF;
        assign bus.wb_adr_i = adr[g];
        assign ack[g] = bus.wb_ack_o;
        assign err[g] = bus.wb_err_o;
        assign dat[g] = bus.wb_dat_o;
        assign csn_w[g] = csn;
        assign sck_w[g] = sck;
        assign sdo_w[g] = so;
        assign cap_cmd[g] = hdr[NH-1 -: 8];
        assign cap_adr[g] = hdr[NH-9 -: 24];
        assign idle_edges[g] = idle_n;

        spi_flash_wb_reader #(
            .ADDR_W(24), .CLK_DIV((g == 2) ? 1 : 2), .FAST_READ((g == 2) ? 1 : 0),
            .CS_HOLD(2), .BIG_ENDIAN((g == 1) ? 0 : 1)
        ) u_dut (
            .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
            .flash_continue(fc[g]), .spi_sck_o(sck), .cs_n(csn),
            .sdi(si), .sdo(so), .wp_n(wpn_w[g]), .hld_n(hldn_w[g])
        );

        // Flash model: byte at address A reads as A[7:0]; data driven on falling SCK.
        always @(sck or csn) begin : model
            logic [23:0] a;
            logic [7:0]  b;
            int          j;
            if (csn_prev && !csn) begin
                rise_n = 0;
                fall_n = 0;
            end
            if (!sck_prev && sck) begin
                if (csn) idle_n++;
                else begin
                    if (rise_n < NH) hdr = {hdr[NH-2:0], so};
                    rise_n++;
                end
            end
            if (sck_prev && !sck && !csn) begin
                fall_n++;
                j = fall_n - NH;
                a = hdr[NH-9 -: 24];
                if (j >= 0 && j < 32) begin
                    b  = 8'(a + 24'(j / 8));
                    si = b[3'(7 - (j % 8))];
                end else begin
                    si = 1'b0;
                end
            end
            sck_prev = sck;
            csn_prev = csn;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [23:0] a, input bit be);
        logic [23:0] base;
        logic [7:0]  b [4];
        base = a & 24'hFFFFFC;
        for (int k = 0; k < 4; k++) b[k] = 8'(base + 24'(k));
        return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    // Issue a read, wait for the accept (cs_n low) and the ack, check against the scoreboard.
    task automatic do_read(input int i, input logic [23:0] a, input int exp_lat,
                           input bit release_bus, output int pre_cnt);
        sb_t e;
        int  n;
        bit  got;
        e.inst = i;
        e.dat  = model_word(a, (i == 1) ? 1'b0 : 1'b1);
        sb.push_back(e);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; adr[i] = a;
        pre_cnt = 0; got = 1'b0;
        while (pre_cnt < 2000 && !got) begin
            @(posedge clk); #1;
            pre_cnt++;
            if (!csn_w[i]) got = 1'b1;
        end
        check("accept", 64'(got), 64'(1));
        n = 0; got = 1'b0;
        while (n < 2000 && !got) begin
            @(posedge clk); #1;
            n++;
            if (ack[i]) got = 1'b1;
        end
        check("ack_seen", 64'(got), 64'(1));
        if (exp_lat > 0) check("latency", 64'(n), 64'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_data", 64'(dat[i]), 64'(e.dat));
        end
        check("spi_cmd", 64'(cap_cmd[i]), 64'((i == 2) ? 8'h0B : 8'h03));
        check("spi_addr", 64'(cap_adr[i]), 64'(a & 24'hFFFFFC));
        if (release_bus) begin
            cyc[i] = 1'b0; stb[i] = 1'b0;
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0; fc[g] = 1'b1; adr[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_pins", 64'({csn_w[g], sck_w[g], sdo_w[g], ack[g], err[g], wpn_w[g], hldn_w[g]}),
                  64'(7'b1000011));
            check("rst_dat", 64'(dat[g]), 64'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic big-endian READ.
        do_read(0, 24'h000104, 259, 1'b1, pre);
        check("accept_first_edge", 64'(pre), 64'(1));
        @(posedge clk); #1;
        check("ack_one_cycle", 64'(ack[0]), 64'(0));
        check("dat_held", 64'(dat[0]), 64'(32'h04050607));

        // Write attempt: one-cycle error, no SPI activity.
        repeat (4) @(posedge clk);
        #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 24'h000040;
        @(posedge clk); #1;
        check("wr_err", 64'({err[0], ack[0], csn_w[0]}), 64'(3'b101));
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
        check("wr_err_clear", 64'(err[0]), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("wr_no_spi", 64'({csn_w[0], sck_w[0]}), 64'(2'b10));
        check("wr_no_sck_edges", 64'(idle_edges[0]), 64'(0));

        // Little-endian lanes and address low-bit clearing.
        do_read(1, 24'h000104, 259, 1'b1, pre);
        repeat (4) @(posedge clk);
        #1;
        do_read(1, 24'h000107, 259, 1'b1, pre);

        // FAST_READ with CLK_DIV=1.
        do_read(2, 24'h000104, 146, 1'b1, pre);

        // flash_continue gates the start but not a running transaction.
        repeat (4) @(posedge clk);
        #1;
        fc[0] = 1'b0;
        fork
            do_read(0, 24'h0003F8, 259, 1'b1, pre);
            begin
                repeat (10) @(posedge clk);
                #2;
                check("fc_gate", 64'(csn_w[0]), 64'(1));
                fc[0] = 1'b1;
                repeat (50) @(posedge clk);
                #2;
                fc[0] = 1'b0;
            end
        join
        fc[0] = 1'b1;
        check("fc_accept_delay", 64'(pre), 64'(11));

        // Abort after the 20th SCK falling edge.
        repeat (4) @(posedge clk);
        #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000200;
        pre = 0;
        while (pre < 100 && csn_w[0]) begin
            @(posedge clk); #1;
            pre++;
        end
        check("abort_accept", 64'(csn_w[0]), 64'(0));
        repeat (82) @(posedge clk);
        #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_pins", 64'({csn_w[0], sck_w[0], sdo_w[0]}), 64'(3'b100));
        n_ack = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (ack[0]) n_ack++;
        end
        check("abort_no_ack", 64'(n_ack), 64'(0));
        check("abort_dat_kept", 64'(dat[0]), 64'(32'hF8F9FAFB));
        do_read(0, 24'h0002A0, 259, 1'b1, pre);

        // Back-to-back reads: master keeps the cycle up and presents the next address.
        repeat (4) @(posedge clk);
        #1;
        do_read(0, 24'h000010, 259, 1'b0, pre);
        do_read(0, 24'h000020, 259, 1'b1, pre2);
        check("b2b_cs_high_min", 64'(pre2 + 1 >= 3), 64'(1));
        check("sck_idle_low", 64'(idle_edges[0] + idle_edges[1] + idle_edges[2]), 64'(0));

        // Asynchronous reset in the middle of a transaction.
        repeat (4) @(posedge clk);
        #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000400;
        repeat (41) @(posedge clk);
        #2;
        check("pre_rst_active", 64'(csn_w[0]), 64'(0));
        rst = 1'b1;
        #1;
        check("midrst_pins", 64'({csn_w[0], sck_w[0], sdo_w[0], ack[0]}), 64'(4'b1000));
        check("midrst_dat", 64'(dat[0]), 64'(0));
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
